simmem_rowbuf_scheduler: RTL and testbench

- Serializes read and write address requests onto the single simulated DRAM bank of simmem.
- Round-robin arbitrates between the read and write address channels. Tracks the open row of the row buffer.
- Holds each accepted request for its modelled service latency: row hit, activation, or precharge+activation, plus burst beats.
- Then emits a release token carrying the internal identifier, so the response/data banks can let the matching response go.

---
 rtl/simmem_pkg.sv | 35 +++
 rtl/simmem_rr_arbiter2.sv | 36 +++
 rtl/simmem_rowbuf_scheduler.sv | 118 +++++++++++
 tb/tb_simmem_rowbuf_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared widths, row-buffer timing costs and scheduler types for the simmem
// single-bank memory model.
package simmem_pkg;

    localparam int unsigned AxAddrWidth            = 16;
    localparam int unsigned AxLenWidth             = 8;
    localparam int unsigned ReadDataBankAddrWidth  = 5;
    localparam int unsigned WriteRespBankAddrWidth = 5;
    localparam int unsigned RowBufferLenWidth      = 8;
    localparam int unsigned RowIdxWidth            = AxAddrWidth - RowBufferLenWidth;

    localparam int unsigned RowHitCost       = 10;
    localparam int unsigned PrechargeCost    = 50;
    localparam int unsigned ActivationCost   = 45;
    localparam int unsigned ServiceCostWidth = 10;

    localparam int unsigned ReleaseIidWidth = ReadDataBankAddrWidth;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_SERVICE,
        SCHED_RELEASE
    } sched_state_e;

    typedef struct packed {
        logic                       is_write;
        logic [ReleaseIidWidth-1:0] iid;
    } release_tok_t;

    // Row index of a byte address within the single bank.
    function automatic logic [RowIdxWidth-1:0] row_of(input logic [AxAddrWidth-1:0] addr);
        return RowIdxWidth'(addr >> RowBufferLenWidth);
    endfunction

endpackage

// File: rtl/simmem_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is read, bit 1 is write.
// The last-grant pointer only advances when a grant is actually accepted.
module simmem_rr_arbiter2
    import simmem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       accept_i,
    output logic [1:0] grant_c
);

    logic last_write_q;

    always_comb begin
        grant_c = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                grant_c = last_write_q ? 2'b01 : 2'b10;
            end else begin
                grant_c = req_i;
            end
        end
    end

    // Reset favours read on the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_write_q <= 1'b1;
        end else if (accept_i) begin
            last_write_q <= grant_c[1];
        end
    end

endmodule

// File: rtl/simmem_rowbuf_scheduler.sv
// Serializes read/write address requests onto one DRAM bank, holding each for its
// row-buffer service latency before issuing a release token for its response.
module simmem_rowbuf_scheduler
    import simmem_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              raddr_valid_i,
    output logic                              raddr_ready_o,
    input  logic [AxAddrWidth-1:0]            raddr_addr_i,
    input  logic [AxLenWidth-1:0]             raddr_len_i,
    input  logic [ReadDataBankAddrWidth-1:0]  raddr_iid_i,
    input  logic                              waddr_valid_i,
    output logic                              waddr_ready_o,
    input  logic [AxAddrWidth-1:0]            waddr_addr_i,
    input  logic [AxLenWidth-1:0]             waddr_len_i,
    input  logic [WriteRespBankAddrWidth-1:0] waddr_iid_i,
    output logic                              release_valid_o,
    input  logic                              release_ready_i,
    output logic                              release_is_write_o,
    output logic [ReleaseIidWidth-1:0]        release_iid_o,
    output logic                              row_open_o,
    output logic [RowIdxWidth-1:0]            open_row_o,
    output logic                              busy_o
);

    sched_state_e                state_q, state_d;
    logic [ServiceCostWidth-1:0] count_q, base, cost;
    logic                        row_open_q;
    logic [RowIdxWidth-1:0]      open_row_q, req_row;
    release_tok_t                tok_q;
    logic [1:0]                  grant;
    logic                        accept, sel_write;
    logic [AxAddrWidth-1:0]      req_addr;
    logic [AxLenWidth-1:0]       req_len;
    logic [ReleaseIidWidth-1:0]  req_iid;

    simmem_rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({waddr_valid_i, raddr_valid_i}),
        .en_i     (state_q == SCHED_IDLE),
        .accept_i (accept),
        .grant_c  (grant)
    );

    assign raddr_ready_o = grant[0];
    assign waddr_ready_o = grant[1];
    assign accept        = |grant;
    assign sel_write     = grant[1];

    always_comb begin
        req_addr = sel_write ? waddr_addr_i : raddr_addr_i;
        req_len  = sel_write ? waddr_len_i  : raddr_len_i;
        req_iid  = sel_write ? ReleaseIidWidth'(waddr_iid_i) : ReleaseIidWidth'(raddr_iid_i);
        req_row  = row_of(req_addr);
    end

    // Service cost: hit, activate on a closed bank, or precharge+activate on a conflict.
    always_comb begin
        if (row_open_q && (req_row == open_row_q)) begin
            base = ServiceCostWidth'(RowHitCost);
        end else if (!row_open_q) begin
            base = ServiceCostWidth'(ActivationCost + RowHitCost);
        end else begin
            base = ServiceCostWidth'(PrechargeCost + ActivationCost + RowHitCost);
        end
        cost = base + ServiceCostWidth'(req_len);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCHED_IDLE:    if (accept) state_d = SCHED_SERVICE;
            SCHED_SERVICE: if (count_q == ServiceCostWidth'(1)) state_d = SCHED_RELEASE;
            SCHED_RELEASE: if (release_ready_i) state_d = SCHED_IDLE;
            default:       state_d = SCHED_IDLE;
        endcase
    end

    // Open-page policy: the row stays open until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            row_open_q <= 1'b0;
            open_row_q <= '0;
            tok_q      <= '0;
        end else if (accept) begin
            count_q    <= cost;
            row_open_q <= 1'b1;
            open_row_q <= req_row;
            tok_q      <= '{is_write: sel_write, iid: req_iid};
        end else if (state_q == SCHED_SERVICE) begin
            count_q <= count_q - ServiceCostWidth'(1);
        end
    end

    assign release_valid_o    = (state_q == SCHED_RELEASE);
    assign release_is_write_o = tok_q.is_write;
    assign release_iid_o      = tok_q.iid;
    assign row_open_o         = row_open_q;
    assign open_row_o         = open_row_q;
    assign busy_o             = (state_q != SCHED_IDLE);

    a_tok_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == SCHED_RELEASE && !release_ready_i) |=> $stable(tok_q));

    a_one_ready: assert property (@(posedge clk_i) !(raddr_ready_o && waddr_ready_o));

endmodule

// File: tb/tb_simmem_rowbuf_scheduler.sv
// Directed and randomized bench for simmem_rowbuf_scheduler against a
// cost/arbitration model derived from the row-buffer timing rules.
module tb_simmem_rowbuf_scheduler;
    import simmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        raddr_valid, raddr_ready, waddr_valid, waddr_ready;
    logic [15:0] raddr_addr, waddr_addr;
    logic [7:0]  raddr_len, waddr_len;
    logic [4:0]  raddr_iid, waddr_iid;
    logic        release_valid, release_ready, release_is_write;
    logic [4:0]  release_iid;
    logic        row_open;
    logic [7:0]  open_row;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_row_open;
    int m_open_row;
    bit m_last_write;
    bit e_write;
    int e_iid;
    int e_cost;

    simmem_rowbuf_scheduler dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .raddr_valid_i      (raddr_valid),
        .raddr_ready_o      (raddr_ready),
        .raddr_addr_i       (raddr_addr),
        .raddr_len_i        (raddr_len),
        .raddr_iid_i        (raddr_iid),
        .waddr_valid_i      (waddr_valid),
        .waddr_ready_o      (waddr_ready),
        .waddr_addr_i       (waddr_addr),
        .waddr_len_i        (waddr_len),
        .waddr_iid_i        (waddr_iid),
        .release_valid_o    (release_valid),
        .release_ready_i    (release_ready),
        .release_is_write_o (release_is_write),
        .release_iid_o      (release_iid),
        .row_open_o         (row_open),
        .open_row_o         (open_row),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_cost(input int addr, input int len);
        int row;
        int base;
        row = addr >> 8;
        if (m_row_open && row == m_open_row) base = 10;
        else if (!m_row_open)                base = 45 + 10;
        else                                 base = 50 + 45 + 10;
        return base + len;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_row_open   = 1'b0;
        m_open_row   = 0;
        m_last_write = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_read(input int a, input int l, input int i);
        raddr_valid = 1'b1;
        raddr_addr  = 16'(a);
        raddr_len   = 8'(l);
        raddr_iid   = 5'(i);
    endtask

    task automatic set_write(input int a, input int l, input int i);
        waddr_valid = 1'b1;
        waddr_addr  = 16'(a);
        waddr_len   = 8'(l);
        waddr_iid   = 5'(i);
    endtask

    // Expects the scheduler idle with at least one valid; checks the grant, then accepts.
    task automatic step_accept(input string tag);
        bit rv;
        bit wv;
        bit win_w;
        int addr;
        rv = raddr_valid;
        wv = waddr_valid;
        win_w = (rv && wv) ? !m_last_write : wv;
        #1;
        chk({tag, "_rready"}, 32'(raddr_ready), 32'(!win_w));
        chk({tag, "_wready"}, 32'(waddr_ready), 32'(win_w));
        if (win_w) begin
            addr   = int'(waddr_addr);
            e_cost = model_cost(addr, int'(waddr_len));
            e_iid  = int'(waddr_iid);
        end else begin
            addr   = int'(raddr_addr);
            e_cost = model_cost(addr, int'(raddr_len));
            e_iid  = int'(raddr_iid);
        end
        tick;
        if (win_w) waddr_valid = 1'b0;
        else       raddr_valid = 1'b0;
        e_write      = win_w;
        m_row_open   = 1'b1;
        m_open_row   = addr >> 8;
        m_last_write = win_w;
        chk({tag, "_row_open"}, 32'(row_open), 32'(1));
        chk({tag, "_open_row"}, 32'(open_row), 32'(m_open_row));
        chk({tag, "_busy"},     32'(busy),     32'(1));
    endtask

    // Waits (bounded) for the release token, optionally stalls it, then hands it off.
    task automatic serve(input string tag, input int hold);
        int n;
        bit rv;
        bit wv;
        n = 0;
        for (int k = 1; k <= e_cost + 20; k++) begin
            tick;
            if (release_valid) begin
                n = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(n), 32'(e_cost));
        chk({tag, "_is_write"}, 32'(release_is_write), 32'(e_write));
        chk({tag, "_iid"}, 32'(release_iid), 32'(e_iid));
        if (hold > 0) begin
            rv = raddr_valid;
            wv = waddr_valid;
            raddr_valid = 1'b1;
            waddr_valid = 1'b1;
            release_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick;
                chk({tag, "_hold_valid"}, 32'(release_valid), 32'(1));
                chk({tag, "_hold_iid"}, 32'(release_iid), 32'(e_iid));
                chk({tag, "_hold_wr"}, 32'(release_is_write), 32'(e_write));
                chk({tag, "_hold_rdy"}, 32'({raddr_ready, waddr_ready}), 32'(0));
            end
            raddr_valid = rv;
            waddr_valid = wv;
        end
        release_ready = 1'b1;
        tick;
        release_ready = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'(0));
        chk({tag, "_rel_clr"}, 32'(release_valid), 32'(0));
    endtask

    initial begin
        bit saw_token;
        rst = 1'b1;
        raddr_valid = 1'b0; raddr_addr = '0; raddr_len = '0; raddr_iid = '0;
        waddr_valid = 1'b0; waddr_addr = '0; waddr_len = '0; waddr_iid = '0;
        release_ready = 1'b0;
        tick;
        tick;
        chk("rst_rel_valid", 32'(release_valid), 32'(0));
        chk("rst_row_open",  32'(row_open), 32'(0));
        chk("rst_open_row",  32'(open_row), 32'(0));
        chk("rst_busy",      32'(busy), 32'(0));
        chk("rst_ready",     32'({raddr_ready, waddr_ready}), 32'(0));
        chk("rst_payload",   32'({release_is_write, release_iid}), 32'(0));
        rst = 1'b0;
        model_reset();

        // Closed bank, hit, conflict, hit with burst, then a stalled release.
        set_read(16'h0123, 0, 5);  step_accept("rd_first"); serve("rd_first", 0);
        set_read(16'h0150, 0, 6);  step_accept("rd_hit");   serve("rd_hit", 0);
        set_write(16'h0200, 0, 9); step_accept("wr_miss");  serve("wr_miss", 0);
        set_write(16'h0210, 3, 10); step_accept("wr_burst"); serve("wr_burst", 0);
        set_read(16'h0220, 0, 11); step_accept("rd_hold");  serve("rd_hold", 20);

        // Simultaneous arrivals alternate, loser stays pending.
        do_reset();
        set_read(16'h0400, 1, 1); set_write(16'h0410, 2, 2);
        step_accept("tie1_rd"); serve("tie1_rd", 0);
        step_accept("tie1_wr"); serve("tie1_wr", 0);
        set_read(16'h0420, 0, 3); set_write(16'h0500, 4, 4);
        step_accept("tie2_rd"); serve("tie2_rd", 0);
        step_accept("tie2_wr"); serve("tie2_wr", 0);

        // Reset while servicing with 30 cycles left drops the request.
        set_read(16'h0300, 0, 7);
        step_accept("abort");
        for (int k = 0; k < e_cost - 30; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        chk("abort_row_open", 32'(row_open), 32'(0));
        chk("abort_open_row", 32'(open_row), 32'(0));
        chk("abort_busy",     32'(busy), 32'(0));
        saw_token = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (release_valid) saw_token = 1'b1;
        end
        chk("abort_no_token", 32'(saw_token), 32'(0));
        set_read(16'h0123, 0, 3); step_accept("post_abort"); serve("post_abort", 0);

        // Randomized traffic over a few rows.
        for (int it = 0; it < 24; it++) begin
            bit rv;
            bit wv;
            rv = 1'($urandom % 2);
            wv = 1'($urandom % 2);
            if (!rv && !wv) rv = 1'b1;
            if (rv) set_read(int'((($urandom % 4) << 8) | ($urandom % 256)),
                             int'($urandom % 16), int'($urandom % 32));
            if (wv) set_write(int'((($urandom % 4) << 8) | ($urandom % 256)),
                              int'($urandom % 16), int'($urandom % 32));
            step_accept("rand");
            raddr_valid = 1'b0;
            waddr_valid = 1'b0;
            serve("rand", int'($urandom % 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
